gomoku_move_scorer: RTL



---
 rtl/gomoku_pkg.sv | 77 +++++++
 rtl/gomoku_line_classify.sv | 46 ++++
 rtl/gomoku_move_scorer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/gomoku_pkg.sv
// Shared types, pattern table and weights for the gomoku move scorer.
// Classes are ordered best-first so a smaller code always wins.
package gomoku_pkg;

  typedef enum logic [3:0] {
    CL_FIVE   = 4'd0,
    CL_FOUR   = 4'd1,
    CL_FFOUR  = 4'd2,
    CL_THREE  = 4'd3,
    CL_FTHREE = 4'd4,
    CL_STHREE = 4'd5,
    CL_TWO    = 4'd6,
    CL_FTWO   = 4'd7,
    CL_STWO   = 4'd8,
    CL_NONE   = 4'd9
  } cls_t;

  localparam int NCLS = 10;

  localparam logic [31:0] ATK_W [NCLS] = '{
    32'd100000, 32'd10000, 32'd1000, 32'd1000, 32'd100,
    32'd100, 32'd100, 32'd10, 32'd10, 32'd0
  };

  localparam logic [31:0] DEF_W [NCLS] = '{
    32'd50000, 32'd5000, 32'd500, 32'd500, 32'd50,
    32'd50, 32'd50, 32'd5, 32'd5, 32'd0
  };

  // cell codes: unused, self stone, empty, other stone
  localparam logic [1:0] CX = 2'd0;
  localparam logic [1:0] CM = 2'd1;
  localparam logic [1:0] CE = 2'd2;
  localparam logic [1:0] CO = 2'd3;

  typedef struct packed {
    cls_t             cls;
    logic [2:0]       len;
    logic [0:5][1:0]  cells;
  } pat_t;

  localparam int NPAT = 20;

  localparam pat_t PATS [NPAT] = '{
    '{CL_FIVE,   3'd5, {CM, CM, CM, CM, CM, CX}},
    '{CL_FOUR,   3'd6, {CE, CM, CM, CM, CM, CE}},
    '{CL_FFOUR,  3'd6, {CO, CM, CM, CM, CM, CE}},
    '{CL_FFOUR,  3'd6, {CE, CM, CM, CM, CM, CO}},
    '{CL_FFOUR,  3'd5, {CM, CE, CM, CM, CM, CX}},
    '{CL_FFOUR,  3'd5, {CM, CM, CE, CM, CM, CX}},
    '{CL_FFOUR,  3'd5, {CM, CM, CM, CE, CM, CX}},
    '{CL_THREE,  3'd5, {CE, CM, CM, CM, CE, CX}},
    '{CL_THREE,  3'd6, {CE, CM, CM, CE, CM, CE}},
    '{CL_THREE,  3'd6, {CE, CM, CE, CM, CM, CE}},
    '{CL_FTHREE, 3'd5, {CO, CE, CM, CM, CM, CX}},
    '{CL_FTHREE, 3'd5, {CM, CM, CM, CE, CO, CX}},
    '{CL_STHREE, 3'd5, {CO, CM, CM, CM, CE, CX}},
    '{CL_STHREE, 3'd5, {CE, CM, CM, CM, CO, CX}},
    '{CL_TWO,    3'd4, {CE, CM, CM, CE, CX, CX}},
    '{CL_TWO,    3'd5, {CE, CM, CE, CM, CE, CX}},
    '{CL_FTWO,   3'd4, {CO, CE, CM, CM, CX, CX}},
    '{CL_FTWO,   3'd4, {CM, CM, CE, CO, CX, CX}},
    '{CL_STWO,   3'd4, {CO, CM, CM, CE, CX, CX}},
    '{CL_STWO,   3'd4, {CE, CM, CM, CO, CX, CX}}
  };

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] max
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

endpackage

// File: rtl/gomoku_line_classify.sv
// Best pattern class of one window line whose match span covers the centre.
module gomoku_line_classify
  import gomoku_pkg::*;
#(
  parameter int WIN = 9
) (
  input  logic [WIN-1:0] self,
  input  logic [WIN-1:0] other,
  output cls_t           cls
);

  localparam int C = (WIN - 1) / 2;

  // zero padding keeps unused pattern cells inside the vector
  logic [WIN+5:0] sp;
  logic [WIN+5:0] opv;

  assign sp  = {6'b0, self};
  assign opv = {6'b0, other};

  always_comb begin
    int   len;
    logic hit;
    cls = CL_NONE;
    len = 0;
    hit = 1'b0;
    for (int p = 0; p < NPAT; p++) begin
      for (int s = 0; s < WIN; s++) begin
        len = int'(PATS[p].len);
        hit = (s <= C) && (s + len - 1 >= C) && (s + len <= WIN);
        for (int k = 0; k < 6; k++) begin
          if (k < len) begin
            case (PATS[p].cells[k])
              CM:      hit = hit & sp[s+k];
              CE:      hit = hit & !sp[s+k] & !opv[s+k];
              CO:      hit = hit & opv[s+k];
              default: hit = hit;
            endcase
          end
        end
        if (hit && (PATS[p].cls < cls)) cls = PATS[p].cls;
      end
    end
  end

endmodule

// File: rtl/gomoku_move_scorer.sv
// Two-stage candidate scorer: per-line classify/weight, then group accumulate.
// in_ready stalls both stages whenever a result is waiting to be taken.
module gomoku_move_scorer
  import gomoku_pkg::*;
#(
  parameter int WIN     = 9,
  parameter int DIRS    = 4,
  parameter int SCORE_W = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIN-1:0]              in_my,
  input  logic [WIN-1:0]              in_op,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SCORE_W-1:0]          out_score,
  output logic                        out_win,
  output logic                        out_block,
  output logic                        out_occupied,
  output logic [$clog2(DIRS+1)-1:0]   out_lines,
  output logic                        out_err
);

  localparam int C  = (WIN - 1) / 2;
  localparam int LW = $clog2(DIRS + 1);
  localparam logic [WIN-1:0] CMASK = WIN'(1) << C;
  localparam logic [32:0] SMAX33 = (33'd1 << SCORE_W) - 33'd1;
  localparam logic [31:0] SMAX = SMAX33[31:0];

  logic          adv;
  logic [WIN-1:0] my_p;
  logic [WIN-1:0] op_p;
  cls_t          cmy;
  cls_t          cop;
  logic          occ;
  logic [31:0]   lscore;

  logic          s1_valid;
  logic          s1_last;
  logic          s1_win;
  logic          s1_block;
  logic          s1_occ;
  logic [31:0]   s1_score;

  logic [31:0]   acc;
  logic [LW-1:0] cnt;
  logic          f_win;
  logic          f_block;
  logic          f_occ;

  logic [31:0]   acc_n;
  logic [LW-1:0] cnt_n;
  logic          win_n;
  logic          block_n;
  logic          occ_n;
  logic          grp_end;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign my_p = in_my | CMASK;
  assign op_p = in_op | CMASK;
  assign occ  = in_my[C] | in_op[C];

  gomoku_line_classify #(.WIN(WIN)) u_cls_my (
    .self  (my_p),
    .other (in_op),
    .cls   (cmy)
  );

  gomoku_line_classify #(.WIN(WIN)) u_cls_op (
    .self  (op_p),
    .other (in_my),
    .cls   (cop)
  );

  assign lscore = occ ? 32'd0 : (ATK_W[cmy] + DEF_W[cop]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_win   <= 1'b0;
      s1_block <= 1'b0;
      s1_occ   <= 1'b0;
      s1_score <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_last  <= in_last;
        s1_win   <= !occ && (cmy == CL_FIVE);
        s1_block <= !occ && (cop == CL_FIVE);
        s1_occ   <= occ;
        s1_score <= lscore;
      end
    end
  end

  assign acc_n   = sat_add(acc, s1_score, SMAX);
  assign cnt_n   = cnt + LW'(1);
  assign win_n   = f_win | s1_win;
  assign block_n = f_block | s1_block;
  assign occ_n   = f_occ | s1_occ;
  assign grp_end = s1_last || (cnt_n == LW'(DIRS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      f_win        <= 1'b0;
      f_block      <= 1'b0;
      f_occ        <= 1'b0;
      out_valid    <= 1'b0;
      out_score    <= '0;
      out_win      <= 1'b0;
      out_block    <= 1'b0;
      out_occupied <= 1'b0;
      out_lines    <= '0;
      out_err      <= 1'b0;
    end else if (adv) begin
      out_valid <= 1'b0;
      if (s1_valid) begin
        if (grp_end) begin
          out_valid    <= 1'b1;
          out_score    <= occ_n ? '0 : acc_n[SCORE_W-1:0];
          out_win      <= win_n;
          out_block    <= block_n;
          out_occupied <= occ_n;
          out_lines    <= cnt_n;
          out_err      <= !s1_last;
          acc          <= '0;
          cnt          <= '0;
          f_win        <= 1'b0;
          f_block      <= 1'b0;
          f_occ        <= 1'b0;
        end else begin
          acc     <= acc_n;
          cnt     <= cnt_n;
          f_win   <= win_n;
          f_block <= block_n;
          f_occ   <= occ_n;
        end
      end
    end
  end

endmodule
